wb_shared_bus_rr: RTL and testbench

Parametrised Wishbone classic shared-bus interconnect with NUM_MASTERS masters and NUM_SLAVES slaves. Only one transfer is in flight at a time. Bus ownership uses round-robin arbitration and is held for as long as the owner keeps cyc asserted. Slaves are selected by decoding the top address bits; unmapped addresses get an internally generated error. The block replaces the fixed 2×2 interconnect between the SPI bridge, the Levenshtein controller and the SRAM SPI controller, and lets further masters and slaves (e.g. a second engine or a debug port) be added without new RTL.

---
 rtl/wb_bus_pkg.sv | 22 ++
 rtl/wb_shared_bus_rr_arbiter.sv | 32 +++
 rtl/wb_shared_bus_rr.sv | 198 +++++++++++++++++++
 tb/tb_wb_shared_bus_rr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// rtl/wb_bus_pkg.sv - shared types and helpers for the Wishbone shared-bus interconnect
package wb_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_shared_bus_rr_arbiter.sv
// rtl/wb_shared_bus_rr_arbiter.sv - combinational round-robin pick starting at ptr_i with wrap
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         en_i,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_valid_o
);

    logic [N-1:0] req_rot;

    always_comb begin
        req_rot     = N'({req_i, req_i} >> ptr_i);
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        // Walk from the far end so the smallest offset from ptr_i wins.
        for (int off = N - 1; off >= 0; off--) begin
            if (en_i && req_rot[off]) begin
                gnt_valid_o = 1'b1;
                if (int'(ptr_i) + off >= N) begin
                    gnt_idx_o = W'(int'(ptr_i) + off - N);
                end else begin
                    gnt_idx_o = W'(int'(ptr_i) + off);
                end
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus_rr.sv
// rtl/wb_shared_bus_rr.sv - Wishbone classic shared bus, round-robin ownership, address decode
// Optional slave watchdog enabled by WB_SHARED_BUS_TIMEOUT_EN.
module wb_shared_bus_rr
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 2,
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_MASTERS-1:0]                  mst_cyc_i,
    input  logic [NUM_MASTERS-1:0]                  mst_stb_i,
    input  logic [NUM_MASTERS-1:0]                  mst_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       mst_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]       mst_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   mst_sel_i,
    output logic [NUM_MASTERS-1:0]                  mst_ack_o,
    output logic [NUM_MASTERS-1:0]                  mst_err_o,
    output logic [NUM_MASTERS-1:0]                  mst_rty_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]       mst_dat_o,
    output logic [NUM_SLAVES-1:0]                   slv_cyc_o,
    output logic [NUM_SLAVES-1:0]                   slv_stb_o,
    output logic [ADDR_WIDTH-1:0]                   slv_adr_o,
    output logic [DATA_WIDTH-1:0]                   slv_dat_o,
    output logic [DATA_WIDTH/8-1:0]                 slv_sel_o,
    output logic                                    slv_we_o,
    input  logic [NUM_SLAVES-1:0]                   slv_ack_i,
    input  logic [NUM_SLAVES-1:0]                   slv_err_i,
    input  logic [NUM_SLAVES-1:0]                   slv_rty_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]        slv_dat_i
);

    localparam int SEL_W = clog2(NUM_SLAVES);
    localparam int OW    = clog2(NUM_MASTERS);
    localparam int BW    = sel_width(DATA_WIDTH);

    bus_state_e              state_q, state_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [OW-1:0]           ptr_q, ptr_d;
    logic                    err_q, err_d;

    logic                    busy;
    logic                    own_cyc, own_stb, own_we;
    logic [ADDR_WIDTH-1:0]   own_adr;
    logic [DATA_WIDTH-1:0]   own_dat;
    logic [BW-1:0]           own_sel;
    logic [SEL_W-1:0]        idx;
    logic                    mapped;
    logic                    s_ack, s_err, s_rty;
    logic [DATA_WIDTH-1:0]   s_dat;
    logic                    unmapped_stb;
    logic                    rearb;
    logic [OW-1:0]           gnt_idx;
    logic                    gnt_valid;

    assign busy = (state_q == BUSY);

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (owner_q == OW'(m)) begin
                own_cyc = mst_cyc_i[m];
                own_stb = mst_stb_i[m];
                own_we  = mst_we_i[m];
                own_adr = mst_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                own_dat = mst_dat_i[m*DATA_WIDTH +: DATA_WIDTH];
                own_sel = mst_sel_i[m*BW +: BW];
            end
        end
    end

    assign idx = own_adr[ADDR_WIDTH-1 -: SEL_W];

    // A decode index with no matching slave is the unmapped case.
    always_comb begin
        mapped = 1'b0;
        s_ack  = 1'b0;
        s_err  = 1'b0;
        s_rty  = 1'b0;
        s_dat  = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (idx == SEL_W'(s)) begin
                mapped = 1'b1;
                s_ack  = slv_ack_i[s];
                s_err  = slv_err_i[s];
                s_rty  = slv_rty_i[s];
                s_dat  = slv_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        slv_cyc_o = '0;
        slv_stb_o = '0;
        slv_adr_o = busy ? own_adr : '0;
        slv_dat_o = busy ? own_dat : '0;
        slv_sel_o = busy ? own_sel : '0;
        slv_we_o  = busy & own_we;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (busy && own_cyc && !err_q && (idx == SEL_W'(s))) begin
                slv_cyc_o[s] = 1'b1;
                slv_stb_o[s] = own_stb;
            end
        end
    end

    always_comb begin
        mst_ack_o = '0;
        mst_err_o = '0;
        mst_rty_o = '0;
        mst_dat_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (busy && (owner_q == OW'(m))) begin
                mst_ack_o[m] = s_ack;
                mst_err_o[m] = s_err | err_q;
                mst_rty_o[m] = s_rty;
                mst_dat_o[m*DATA_WIDTH +: DATA_WIDTH] = s_dat;
            end
        end
    end

    assign rearb        = !busy || !own_cyc;
    assign unmapped_stb = busy & own_cyc & own_stb & ~mapped;

    rr_arbiter #(
        .N (NUM_MASTERS),
        .W (OW)
    ) u_arb (
        .req_i       (mst_cyc_i),
        .ptr_i       (ptr_q),
        .en_i        (rearb),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (rearb) begin
            if (gnt_valid) begin
                state_d = BUSY;
                owner_d = gnt_idx;
                ptr_d   = (gnt_idx == OW'(NUM_MASTERS - 1)) ? '0 : OW'(gnt_idx + 1'b1);
            end else begin
                state_d = IDLE;
            end
        end
    end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    localparam int WDG_W = clog2(TIMEOUT_CYCLES);

    logic [WDG_W-1:0] wdg_q, wdg_d;
    logic             stall;
    logic             wdg_fire;

    always_comb begin
        stall    = (|slv_stb_o) & ~(s_ack | s_err | s_rty);
        wdg_fire = stall && (wdg_q == WDG_W'(TIMEOUT_CYCLES - 1));
        wdg_d    = (stall && !wdg_fire) ? WDG_W'(wdg_q + 1'b1) : '0;
        err_d    = (unmapped_stb & ~err_q) | wdg_fire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdg_q <= '0;
        end else begin
            wdg_q <= wdg_d;
        end
    end
`else
    assign err_d = unmapped_stb & ~err_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus_rr.sv
// tb/tb_wb_shared_bus_rr.sv - directed scoreboard bench for wb_shared_bus_rr
module tb_wb_shared_bus_rr;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 23;
    localparam int DW = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [NM-1:0]      m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat;
    logic [NM-1:0]      m_sel;

    logic [NM-1:0]      mst_ack, mst_err, mst_rty;
    logic [NM*DW-1:0]   mst_dat;
    logic [NS-1:0]      slv_cyc, slv_stb;
    logic [AW-1:0]      slv_adr;
    logic [DW-1:0]      slv_wdat;
    logic [0:0]         slv_sel;
    logic               slv_we;
    logic [NS-1:0]      slv_ack, slv_err, slv_rty;
    logic [NS*DW-1:0]   slv_rdat;

    logic [NM-1:0]      mst_ack3, mst_err3, mst_rty3;
    logic [NM*DW-1:0]   mst_dat3;
    logic [2:0]         slv_cyc3, slv_stb3;
    logic [AW-1:0]      slv_adr3;
    logic [DW-1:0]      slv_wdat3;
    logic [0:0]         slv_sel3;
    logic               slv_we3;
    logic [2:0]         s3_ack, s3_err, s3_rty;
    logic [3*DW-1:0]    s3_rdat;

    wb_shared_bus_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mst_cyc_i(m_cyc), .mst_stb_i(m_stb), .mst_we_i(m_we),
        .mst_adr_i(m_adr), .mst_dat_i(m_dat), .mst_sel_i(m_sel),
        .mst_ack_o(mst_ack), .mst_err_o(mst_err), .mst_rty_o(mst_rty), .mst_dat_o(mst_dat),
        .slv_cyc_o(slv_cyc), .slv_stb_o(slv_stb), .slv_adr_o(slv_adr),
        .slv_dat_o(slv_wdat), .slv_sel_o(slv_sel), .slv_we_o(slv_we),
        .slv_ack_i(slv_ack), .slv_err_i(slv_err), .slv_rty_i(slv_rty), .slv_dat_i(slv_rdat)
    );

    wb_shared_bus_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .mst_cyc_i(m_cyc), .mst_stb_i(m_stb), .mst_we_i(m_we),
        .mst_adr_i(m_adr), .mst_dat_i(m_dat), .mst_sel_i(m_sel),
        .mst_ack_o(mst_ack3), .mst_err_o(mst_err3), .mst_rty_o(mst_rty3), .mst_dat_o(mst_dat3),
        .slv_cyc_o(slv_cyc3), .slv_stb_o(slv_stb3), .slv_adr_o(slv_adr3),
        .slv_dat_o(slv_wdat3), .slv_sel_o(slv_sel3), .slv_we_o(slv_we3),
        .slv_ack_i(s3_ack), .slv_err_i(s3_err), .slv_rty_i(s3_rty), .slv_dat_i(s3_rdat)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [63:0] obs);
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb_q.size() > 0) chk(tag, obs, sb_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setm(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_we[m]  = we;
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = dat;
        m_sel[m] = cyc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mresp"}, 64'({mst_ack, mst_err, mst_rty}), 64'd0);
        chk({tag, "_mdat"},  64'(mst_dat), 64'd0);
        chk({tag, "_scyc"},  64'({slv_cyc, slv_stb}), 64'd0);
        chk({tag, "_sbus"},  64'({slv_adr, slv_wdat, slv_sel, slv_we}), 64'd0);
        chk({tag, "_dut3"},  64'({mst_ack3, mst_err3, slv_cyc3, slv_stb3, slv_adr3, slv_we3}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        slv_ack = '0; slv_err = '0; slv_rty = '0; slv_rdat = '0;
        s3_ack = '0; s3_err = '0; s3_rty = '0; s3_rdat = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single read by master 0 to slave 0.
        setm(0, 1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
        #1 chk("rd_pre_grant_cyc", 64'(slv_cyc), 64'b00);
        tick();
        chk("rd_grant_cyc", 64'(slv_cyc), 64'b01);
        chk("rd_grant_stb", 64'(slv_stb), 64'b01);
        chk("rd_adr", 64'(slv_adr), 64'h000010);
        sb_q.push_back(64'hA5);
        slv_rdat[7:0] = 8'hA5;
        slv_ack = 2'b01;
        #1 chk("rd_ack", 64'(mst_ack), 64'b01);
        sb_chk("rd_data", 64'(mst_dat[7:0]));
        chk("rd_nonowner_dat", 64'(mst_dat[15:8]), 64'h00);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        slv_ack = '0;
        tick();
        chk("rd_release_cyc", 64'(slv_cyc), 64'b00);

        // Reset asserted between edges while master 0 owns the bus.
        setm(0, 1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
        tick();
        slv_ack = 2'b01;
        #1 chk("mid_pre_ack", 64'(mst_ack), 64'b01);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        slv_ack = '0;

        // Both masters request right as reset releases.
        setm(1, 1'b1, 1'b1, 1'b0, 23'h000020, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("both_first_adr", 64'(slv_adr), 64'h000010);
        slv_ack = 2'b01;
        #1 chk("both_first_ack", 64'(mst_ack), 64'b01);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        slv_ack = '0;
        tick();
        chk("handover_adr", 64'(slv_adr), 64'h000020);
        chk("handover_stb", 64'(slv_stb), 64'b01);
        slv_ack = 2'b01;
        #1 chk("handover_ack", 64'(mst_ack), 64'b10);
        setm(1, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        slv_ack = '0;
        tick();
        setm(0, 1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
        setm(1, 1'b1, 1'b1, 1'b0, 23'h000020, 8'h00);
        tick();
        chk("wrap_owner_adr", 64'(slv_adr), 64'h000010);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        setm(1, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        tick();

        // Master 1 locks the bus across three writes while master 0 waits.
        setm(0, 1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
        setm(1, 1'b1, 1'b1, 1'b1, 23'h400000, 8'h11);
        tick();
        chk("lock_owner_cyc", 64'(slv_cyc), 64'b10);
        chk("lock_we_sel", 64'({slv_we, slv_sel}), 64'b11);
        for (int i = 0; i < 3; i++) begin
            setm(1, 1'b1, 1'b1, 1'b1, 23'h400000 + 23'(i), 8'(8'h11 * (i + 1)));
            sb_q.push_back(64'({23'h400000 + 23'(i), 8'(8'h11 * (i + 1))}));
            #1 sb_chk("lock_wr_slave", 64'({slv_adr, slv_wdat}));
            slv_ack = 2'b10;
            #1 chk("lock_wr_ack", 64'(mst_ack), 64'b10);
            tick();
            slv_ack = '0;
        end
        setm(1, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        #1 chk("lock_m0_waits", 64'(mst_ack), 64'b00);
        tick();
        chk("unlock_cyc", 64'(slv_cyc), 64'b01);
        slv_ack = 2'b01;
        #1 chk("unlock_ack", 64'(mst_ack), 64'b01);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        slv_ack = '0;
        tick();

        // Unmapped address on the three-slave instance; mapped to slave 1 on the two-slave one.
        setm(0, 1'b1, 1'b1, 1'b0, 23'h600000, 8'h00);
        tick();
        chk("unmap_first_err", 64'(mst_err3), 64'b00);
        chk("unmap_no_cyc", 64'({slv_cyc3, slv_stb3}), 64'd0);
        chk("map2_cyc", 64'(slv_cyc), 64'b10);
        tick();
        chk("unmap_err", 64'(mst_err3), 64'b01);
        chk("unmap_no_cyc2", 64'(slv_cyc3), 64'd0);
        tick();
        chk("unmap_err_gap", 64'(mst_err3), 64'b00);
        tick();
        chk("unmap_err_again", 64'(mst_err3), 64'b01);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        tick();
        chk("unmap_release", 64'({mst_err3, slv_cyc3}), 64'd0);

`ifdef WB_SHARED_BUS_TIMEOUT_EN
        // Silent slave 0: watchdog error after TO cycles of strobe.
        setm(0, 1'b1, 1'b1, 1'b0, 23'h000010, 8'h00);
        tick();
        chk("wdg_stb_rise", 64'(slv_stb), 64'b01);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("wdg_wait_err", 64'(mst_err), 64'b00);
            chk("wdg_wait_stb", 64'(slv_stb), 64'b01);
        end
        tick();
        chk("wdg_err", 64'(mst_err), 64'b01);
        chk("wdg_stb_forced", 64'(slv_stb), 64'b00);
        setm(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h00);
        tick();
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
